// File: rtl/uart_sram_loader.sv
// rtl/uart_sram_loader.sv - byte stream to SRAM word loader with header strip and endian packing
module uart_sram_loader #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 16,
  parameter int HEADER_LINES = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Initialize,
  input  logic                  Enable,
  input  logic [ADDR_WIDTH-1:0] Start_address,
  input  logic [ADDR_WIDTH-1:0] Word_count,
  input  logic                  Little_endian,
  input  logic [7:0]            RX_data,
  input  logic                  RX_empty,
  output logic                  RX_unload,
  output logic                  RX_enable,
  output logic [ADDR_WIDTH-1:0] SRAM_address,
  output logic [DATA_WIDTH-1:0] SRAM_write_data,
  output logic                  SRAM_we_n,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH-1:0] Words_written
);

  localparam int                  BPW      = DATA_WIDTH / 8;
  localparam logic [1:0]          IDX_LAST = 2'(BPW - 1);
  localparam logic [2:0]          LF_GOAL  = 3'(HEADER_LINES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

  typedef enum logic [2:0] {
    IDLE, STRIP_WAIT, STRIP_ACK, BYTE_WAIT, BYTE_ACK, WRITE, DONE
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_n, words_n, count_q, count_n, words_inc;
  logic [DATA_WIDTH-1:0]   wdata_n, asm_q, asm_n;
  logic                    we_n_n, unload_n, rxen_n, busy_n, done_n, le_q, le_n;
  logic [1:0]              idx_q, idx_n, lane;
  logic [2:0]              lf_q, lf_n;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state           <= IDLE;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      RX_unload       <= 1'b0;
      RX_enable       <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      Words_written   <= '0;
      idx_q           <= '0;
      lf_q            <= '0;
      asm_q           <= '0;
      count_q         <= '0;
      le_q            <= 1'b0;
    end else begin
      state           <= state_n;
      SRAM_address    <= addr_n;
      SRAM_write_data <= wdata_n;
      SRAM_we_n       <= we_n_n;
      RX_unload       <= unload_n;
      RX_enable       <= rxen_n;
      Busy            <= busy_n;
      Done            <= done_n;
      Words_written   <= words_n;
      idx_q           <= idx_n;
      lf_q            <= lf_n;
      asm_q           <= asm_n;
      count_q         <= count_n;
      le_q            <= le_n;
    end
  end

  assign words_inc = Words_written + ADDR_WIDTH'(1);
  // Big-endian streams fill the word from the top lane downwards.
  assign lane = le_q ? idx_q : (IDX_LAST - idx_q);

  always_comb begin
    state_n  = state;
    addr_n   = SRAM_address;
    wdata_n  = SRAM_write_data;
    we_n_n   = SRAM_we_n;
    unload_n = RX_unload;
    rxen_n   = RX_enable;
    busy_n   = Busy;
    done_n   = Done;
    words_n  = Words_written;
    idx_n    = idx_q;
    lf_n     = lf_q;
    asm_n    = asm_q;
    count_n  = count_q;
    le_n     = le_q;
    if (Initialize) begin
      state_n  = IDLE;
      addr_n   = '0;
      wdata_n  = '0;
      we_n_n   = 1'b1;
      unload_n = 1'b0;
      rxen_n   = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      words_n  = '0;
      idx_n    = '0;
      lf_n     = '0;
      asm_n    = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Enable) begin
            count_n = Word_count;
            le_n    = Little_endian;
            addr_n  = Start_address;
            words_n = '0;
            idx_n   = '0;
            lf_n    = '0;
            asm_n   = '0;
            busy_n  = 1'b1;
            done_n  = 1'b0;
            rxen_n  = 1'b1;
            state_n = (HEADER_LINES > 0) ? STRIP_WAIT : BYTE_WAIT;
          end
        end
        STRIP_WAIT: begin
          if (!RX_empty) begin
            unload_n = 1'b1;
            if (RX_data == 8'h0A) lf_n = lf_q + 3'd1;
            state_n = STRIP_ACK;
          end
        end
        STRIP_ACK: begin
          if (RX_empty) begin
            unload_n = 1'b0;
            state_n  = (lf_q == LF_GOAL) ? BYTE_WAIT : STRIP_WAIT;
          end
        end
        BYTE_WAIT: begin
          if (!RX_empty) begin
            unload_n = 1'b1;
            asm_n[{lane, 3'b000} +: 8] = RX_data;
            state_n  = BYTE_ACK;
          end
        end
        BYTE_ACK: begin
          if (RX_empty) begin
            unload_n = 1'b0;
            if (idx_q == IDX_LAST) begin
              wdata_n = asm_q;
              we_n_n  = 1'b0;
              idx_n   = '0;
              state_n = WRITE;
            end else begin
              idx_n   = idx_q + 2'd1;
              state_n = BYTE_WAIT;
            end
          end
        end
        WRITE: begin
          we_n_n  = 1'b1;
          words_n = words_inc;
          // Stop at the programmed count or the top address; never wrap to 0.
          if ((count_q != '0 && words_inc == count_q) || SRAM_address == ADDR_TOP) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            rxen_n  = 1'b0;
            state_n = DONE;
          end else begin
            addr_n  = SRAM_address + ADDR_WIDTH'(1);
            state_n = BYTE_WAIT;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sram_loader.sv
// tb/tb_uart_sram_loader.sv - scoreboard bench for uart_sram_loader (16-bit, 16-bit+header, 32-bit)
module tb_uart_sram_loader;

  typedef struct {
    logic [17:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        Clock;
  logic        Reset, Initialize, enable_s, rx_empty_s, Little_endian;
  logic [17:0] Start_address, Word_count;
  logic [7:0]  RX_data;
  int          sel;

  logic        en_a[3], empty_a[3], unload_a[3], rxen_a[3], we_a[3], busy_a[3], done_a[3];
  logic [17:0] addr_a[3], ww_a[3];
  logic [31:0] wd_a[3];

  wr_t         exp_q[$];
  logic [7:0]  byte_q[$];
  int          vectors, miscompares;
  int          overlap, max_overlap, max_delay, delay_cnt;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW = (g == 2) ? 32 : 16;
    localparam int HL = (g == 1) ? 3 : 0;
    logic [DW-1:0] wd_l;
    assign en_a[g]    = enable_s && (sel == g);
    assign empty_a[g] = (sel == g) ? rx_empty_s : 1'b1;
    assign wd_a[g]    = 32'(wd_l);
    uart_sram_loader #(.ADDR_WIDTH(18), .DATA_WIDTH(DW), .HEADER_LINES(HL)) u_dut (
      .Clock(Clock), .Reset(Reset), .Initialize(Initialize), .Enable(en_a[g]),
      .Start_address(Start_address), .Word_count(Word_count), .Little_endian(Little_endian),
      .RX_data(RX_data), .RX_empty(empty_a[g]), .RX_unload(unload_a[g]), .RX_enable(rxen_a[g]),
      .SRAM_address(addr_a[g]), .SRAM_write_data(wd_l), .SRAM_we_n(we_a[g]),
      .Busy(busy_a[g]), .Done(done_a[g]), .Words_written(ww_a[g])
    );
  end

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Receiver model plus write monitor, both on the falling edge.
  initial begin
    wr_t e;
    forever begin
      @(negedge Clock);
      if (we_a[sel] === 1'b0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got addr=%h data=%h, required no write", addr_a[sel], wd_a[sel]);
        end else begin
          e = exp_q.pop_front();
          if (addr_a[sel] !== e.addr || wd_a[sel] !== e.data) begin
            miscompares++;
            $display("FAIL sram_write: got addr=%h data=%h, required addr=%h data=%h",
                     addr_a[sel], wd_a[sel], e.addr, e.data);
          end
        end
      end
      if (!rx_empty_s && unload_a[sel]) begin
        void'(byte_q.pop_front());
        rx_empty_s = 1'b1;
        delay_cnt  = $urandom_range(0, max_delay);
      end else if (rx_empty_s && !unload_a[sel] && byte_q.size() > 0) begin
        if (delay_cnt > 0) delay_cnt--;
        else begin
          RX_data    = byte_q[0];
          rx_empty_s = 1'b0;
        end
      end
      if (unload_a[sel] && rx_empty_s) overlap++;
      else overlap = 0;
      if (overlap > max_overlap) max_overlap = overlap;
    end
  end

  task automatic push_wr(input logic [17:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic run_transfer(input int s, input logic [17:0] start, input logic [17:0] cnt,
                              input logic le, input logic [17:0] exp_words, input logic [17:0] exp_last);
    int t;
    sel = s;
    Start_address = start;
    Word_count = cnt;
    Little_endian = le;
    @(negedge Clock);
    enable_s = 1'b1;
    @(negedge Clock);
    enable_s = 1'b0;
    Start_address = 18'h2AAAA;
    Word_count = 18'd7;
    Little_endian = ~le;
    vectors++;
    if (busy_a[sel] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_enable: got %b, required 1", busy_a[sel]);
    end
    t = 0;
    while (done_a[sel] !== 1'b1 && t < 3000) begin
      @(negedge Clock);
      t++;
    end
    vectors++;
    if (done_a[sel] !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout: got done=%b, required 1 within 3000 cycles", done_a[sel]);
    end
    vectors++;
    if (ww_a[sel] !== exp_words || busy_a[sel] !== 1'b0 || rxen_a[sel] !== 1'b0 || addr_a[sel] !== exp_last) begin
      miscompares++;
      $display("FAIL end_status: got words=%0d busy=%b rx_en=%b addr=%h, required words=%0d busy=0 rx_en=0 addr=%h",
               ww_a[sel], busy_a[sel], rxen_a[sel], addr_a[sel], exp_words, exp_last);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (we_a[i] !== 1'b1 || busy_a[i] !== 1'b0 || done_a[i] !== 1'b0 || ww_a[i] !== 18'd0 ||
          addr_a[i] !== 18'd0 || wd_a[i] !== 32'd0 || unload_a[i] !== 1'b0 || rxen_a[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got we_n=%b busy=%b done=%b words=%h addr=%h data=%h unload=%b rx_en=%b, required 1 0 0 0 0 0 0 0",
                 i, we_a[i], busy_a[i], done_a[i], ww_a[i], addr_a[i], wd_a[i], unload_a[i], rxen_a[i]);
      end
    end
  endtask

  task automatic test_big_endian();
    byte_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    push_wr(18'd76800, 32'h1234);
    push_wr(18'd76801, 32'h5678);
    run_transfer(0, 18'd76800, 18'd2, 1'b0, 18'd2, 18'd76801);
  endtask

  task automatic test_back_to_back_little_endian();
    byte_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    push_wr(18'd76800, 32'h3412);
    push_wr(18'd76801, 32'h7856);
    run_transfer(0, 18'd76800, 18'd2, 1'b1, 18'd2, 18'd76801);
  endtask

  task automatic test_header_strip();
    string hdr = "P6\n320 240\n255\n";
    for (int i = 0; i < hdr.len(); i++) byte_q.push_back(hdr[i]);
    byte_q.push_back(8'hAB);
    byte_q.push_back(8'hCD);
    push_wr(18'h01000, 32'hABCD);
    run_transfer(1, 18'h01000, 18'd1, 1'b0, 18'd1, 18'h01000);
  endtask

  task automatic test_wide_slow_receiver();
    max_delay = 20;
    max_overlap = 0;
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_wr(18'h00321, 32'h01020304);
    run_transfer(2, 18'h00321, 18'd1, 1'b0, 18'd1, 18'h00321);
    vectors++;
    if (max_overlap > 1) begin
      miscompares++;
      $display("FAIL unload_overlap: got %0d cycles, required <= 1", max_overlap);
    end
    max_delay = 0;
  endtask

  task automatic test_top_address();
    byte_q = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1, 8'hC2};
    push_wr(18'h3FFFE, 32'hA1A2);
    push_wr(18'h3FFFF, 32'hB1B2);
    run_transfer(0, 18'h3FFFE, 18'd0, 1'b0, 18'd2, 18'h3FFFF);
    repeat (10) @(negedge Clock);
    vectors++;
    if (byte_q.size() != 2) begin
      miscompares++;
      $display("FAIL leftover_bytes: got %0d, required 2", byte_q.size());
    end
    @(posedge Clock);
    #1;
    byte_q.delete();
    rx_empty_s = 1'b1;
  endtask

  task automatic test_initialize_abort();
    int t;
    sel = 0;
    byte_q = '{8'hAA};
    Start_address = 18'd100;
    Word_count = 18'd1;
    Little_endian = 1'b0;
    @(negedge Clock);
    enable_s = 1'b1;
    @(negedge Clock);
    enable_s = 1'b0;
    t = 0;
    while ((byte_q.size() != 0 || unload_a[0] !== 1'b0) && t < 200) begin
      @(negedge Clock);
      t++;
    end
    vectors++;
    if (byte_q.size() != 0 || unload_a[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL first_byte_timeout: got %0d bytes queued, required 0", byte_q.size());
    end
    Initialize = 1'b1;
    @(negedge Clock);
    Initialize = 1'b0;
    vectors++;
    if (we_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || ww_a[0] !== 18'd0 ||
        addr_a[0] !== 18'd0 || wd_a[0] !== 32'd0 || unload_a[0] !== 1'b0 || rxen_a[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL initialize_state: got we_n=%b busy=%b done=%b words=%h addr=%h data=%h unload=%b rx_en=%b, required 1 0 0 0 0 0 0 0",
               we_a[0], busy_a[0], done_a[0], ww_a[0], addr_a[0], wd_a[0], unload_a[0], rxen_a[0]);
    end
    byte_q = '{8'h12, 8'hEF};
    push_wr(18'd200, 32'h12EF);
    run_transfer(0, 18'd200, 18'd1, 1'b0, 18'd1, 18'd200);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    overlap = 0;
    max_overlap = 0;
    max_delay = 0;
    delay_cnt = 0;
    sel = 0;
    Reset = 1'b1;
    Initialize = 1'b0;
    enable_s = 1'b0;
    rx_empty_s = 1'b1;
    RX_data = 8'h00;
    Start_address = '0;
    Word_count = '0;
    Little_endian = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    test_reset();
    test_big_endian();
    test_back_to_back_little_endian();
    test_header_strip();
    test_wide_slow_receiver();
    test_top_address();
    test_initialize_abort();
    repeat (5) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
